// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: issues sequential ICache requests under a credit limit,
// buffers responses in a small FIFO and hands them to decode; redirects flush and drop stale data.
module fetch_ctrl #(
  parameter int              ADDR      = 32,
  parameter int              INST      = 32,
  parameter int              BUF_DEPTH = 4,
  parameter logic [ADDR-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            fetch_e_,
  output logic [ADDR-1:0] fetch_pc,
  input  logic            ic_e_,
  input  logic [ADDR-1:0] ic_pc,
  input  logic [INST-1:0] ic_inst,
  output logic            inst_e_,
  output logic [ADDR-1:0] inst_pc,
  output logic [INST-1:0] inst,
  input  logic            dec_stall,
  input  logic            redirect_e_,
  input  logic [ADDR-1:0] redirect_pc
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [ADDR-1:0] PC_STEP = ADDR'(INST / 8);

  logic [1:0]      state_q, state_d;
  logic [ADDR-1:0] pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [ADDR-1:0] buf_pc_q   [BUF_DEPTH];
  logic [INST-1:0] buf_inst_q [BUF_DEPTH];

  logic            redir, resp, issue, pop, push;
  logic [CW+1:0]   occ;

  // Credits cover stale requests too, so the buffer can never overflow.
  assign occ = (CW+2)'(inflight_q) + (CW+2)'(drop_q) + (CW+2)'(count_q);

  always_comb begin
    redir = ~redirect_e_;
    resp  = ~ic_e_;
    issue = ~reset && ~redir && (state_q != ST_BOOT) && (occ < (CW+2)'(BUF_DEPTH));
    pop   = ~redir && (count_q != '0) && ~dec_stall;
    push  = ~redir && resp && (drop_q == '0);

    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (redir) begin
      pc_d       = redirect_pc;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      inflight_d = '0;
      drop_d     = drop_q + inflight_q - CW'(resp);
    end else begin
      if (issue) pc_d = pc_q + PC_STEP;
      if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
      inflight_d = inflight_q + CW'(issue) - CW'(push);
      count_d    = count_q + CW'(push) - CW'(pop);
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
    end

    if (state_q == ST_BOOT) state_d = ST_RUN;
    else                    state_d = (drop_d != '0) ? ST_DROP : ST_RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]   <= '0;
        buf_inst_q[i] <= '0;
      end
    end else if (push) begin
      buf_pc_q[tail_q]   <= ic_pc;
      buf_inst_q[tail_q] <= ic_inst;
    end
  end

  assign fetch_e_ = ~issue;
  assign fetch_pc = pc_q;
  assign inst_e_  = ~((count_q != '0) && redirect_e_);
  assign inst_pc  = buf_pc_q[head_q];
  assign inst     = buf_inst_q[head_q];

  // A live response into a full buffer means the ICache broke the one-response-per-request contract.
  overflow_chk: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == CW'(BUF_DEPTH))));
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: an in-order ICache model with fixed latency and a scoreboard of
// instructions that should reach decode, tagged by redirect epoch so stale responses are excluded.
module tb_fetch_ctrl;
  localparam int ADDR  = 32;
  localparam int INST  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            fetch_e_;
  logic [ADDR-1:0] fetch_pc;
  logic            ic_e_ = 1'b1;
  logic [ADDR-1:0] ic_pc = '0;
  logic [INST-1:0] ic_inst = '0;
  logic            inst_e_;
  logic [ADDR-1:0] inst_pc;
  logic [INST-1:0] inst;
  logic            dec_stall = 1'b0;
  logic            redirect_e_ = 1'b1;
  logic [ADDR-1:0] redirect_pc = '0;

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR(ADDR), .INST(INST), .BUF_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset),
    .fetch_e_(fetch_e_), .fetch_pc(fetch_pc),
    .ic_e_(ic_e_), .ic_pc(ic_pc), .ic_inst(ic_inst),
    .inst_e_(inst_e_), .inst_pc(inst_pc), .inst(inst),
    .dec_stall(dec_stall),
    .redirect_e_(redirect_e_), .redirect_pc(redirect_pc)
  );

  typedef struct { int due; logic [31:0] pc; int epoch; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  req_t        pend[$];
  ent_t        expq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  int          epoch = 0;
  int          n_req = 0;
  logic        stall = 1'b0;
  logic        redir_now = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] exp_pc = '0;
  logic        s_fetch_n, s_inst_n;
  logic [31:0] s_fetch_pc, s_inst_pc;
  logic        got_first = 1'b0;
  logic [31:0] first_del_pc = '0;

  function automatic logic [31:0] inst_of(logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic cycle();
    req_t r;
    ent_t e;
    @(posedge clk); #1;
    cyc++;
    redirect_e_ = ~redir_now;
    redirect_pc = redir_tgt;
    dec_stall   = stall;
    if (redir_now) epoch++;
    ic_e_ = 1'b1; ic_pc = '0; ic_inst = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      ic_e_ = 1'b0; ic_pc = r.pc; ic_inst = inst_of(r.pc);
      if (r.epoch == epoch) begin
        e.pc = r.pc; e.ins = inst_of(r.pc);
        expq.push_back(e);
      end
    end
    if (redir_now) expq.delete();

    @(negedge clk);
    s_fetch_n = fetch_e_; s_fetch_pc = fetch_pc;
    s_inst_n  = inst_e_;  s_inst_pc  = inst_pc;
    if (fetch_e_ === 1'b0) begin
      check("fetch_pc", fetch_pc, exp_pc);
      r.due = cyc + lat; r.pc = fetch_pc; r.epoch = epoch;
      pend.push_back(r);
      exp_pc = exp_pc + 32'd4;
      n_req++;
    end
    if (redir_now) exp_pc = redir_tgt;
    if (inst_e_ === 1'b0 && !stall) begin
      if (expq.size() == 0) begin
        check("spurious_delivery", {63'd0, inst_e_}, 64'd1);
      end else begin
        e = expq.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst", inst, e.ins);
        if (!got_first) begin
          got_first = 1'b1;
          first_del_pc = inst_pc;
        end
      end
    end
  endtask

  task automatic do_reset(int new_lat);
    @(posedge clk); #3;
    reset = 1'b1;
    redir_now = 1'b0; stall = 1'b0;
    ic_e_ = 1'b1; redirect_e_ = 1'b1; dec_stall = 1'b0;
    #1;
    check("rst_fetch_e_", fetch_e_, 1);
    check("rst_fetch_pc", fetch_pc, 0);
    check("rst_inst_e_", inst_e_, 1);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst", inst, 0);
    pend.delete(); expq.delete();
    exp_pc = '0; lat = new_lat; got_first = 1'b0; n_req = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    @(negedge clk);
    check("boot_fetch_e_", fetch_e_, 1);
    check("boot_inst_e_", inst_e_, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential stream, 1-cycle ICache, no stall
    do_reset(1);
    cycle();
    check("c1_fetch_e_", s_fetch_n, 0);
    check("c1_fetch_pc", s_fetch_pc, 0);
    cycle();
    check("c2_inst_e_", s_inst_n, 1);
    cycle();
    check("c3_inst_e_", s_inst_n, 0);
    check("c3_inst_pc", s_inst_pc, 0);
    for (int i = 0; i < 9; i++) begin
      cycle();
      check("stream_inst_e_", s_inst_n, 0);
      check("stream_fetch_e_", s_fetch_n, 0);
    end

    // Decode stall fills the buffer, then drains back-to-back
    do_reset(2);
    stall = 1'b1;
    repeat (10) cycle();
    check("stall_req_count", n_req, 4);
    check("stall_fetch_e_", s_fetch_n, 1);
    check("stall_inst_e_", s_inst_n, 0);
    stall = 1'b0;
    cycle();
    check("drain0_pc", s_inst_pc, 32'h0);
    cycle();
    check("drain1_pc", s_inst_pc, 32'h4);
    check("resume_fetch_e_", s_fetch_n, 0);
    check("resume_fetch_pc", s_fetch_pc, 32'h10);
    cycle();
    check("drain2_pc", s_inst_pc, 32'h8);
    cycle();
    check("drain3_pc", s_inst_pc, 32'hC);
    repeat (6) cycle();

    // Asynchronous reset with a full buffer, then clean restart
    do_reset(2);
    stall = 1'b1;
    repeat (10) cycle();
    check("full_inst_e_", s_inst_n, 0);
    do_reset(1);
    repeat (3) cycle();
    check("restart_inst_e_", s_inst_n, 0);
    check("restart_first_pc", first_del_pc, 32'h0);
    repeat (8) cycle();

    // Redirects with a 3-cycle ICache: one from RUN, one while still dropping
    do_reset(3);
    repeat (5) cycle();
    check("pre_redir_count", expq.size(), 1);
    redir_now = 1'b1; redir_tgt = 32'h100;
    cycle();
    check("redir_inst_e_", s_inst_n, 1);
    check("redir_fetch_e_", s_fetch_n, 1);
    redir_now = 1'b0; got_first = 1'b0;
    cycle();
    check("r1_fetch_e_", s_fetch_n, 0);
    check("r1_fetch_pc", s_fetch_pc, 32'h100);
    check("r1_inst_e_", s_inst_n, 1);
    redir_now = 1'b1; redir_tgt = 32'h200;
    cycle();
    check("redir2_fetch_e_", s_fetch_n, 1);
    redir_now = 1'b0; got_first = 1'b0;
    cycle();
    check("r2_fetch_pc", s_fetch_pc, 32'h200);
    repeat (20) cycle();
    check("r2_got_delivery", got_first, 1);
    check("r2_first_pc", first_del_pc, 32'h200);
    check("r2_streaming", s_inst_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
